hatch_ctrl: RTL



---
 rtl/hatch_ctrl_if.sv | 47 ++++
 rtl/hatch_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hatch_ctrl_if.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module   : hatch_ctrl_if
// Purpose  : Bundles the game-control inputs and display-facing outputs of
//            the egg-hatching controller.
// Signals  : st    - game enable level (0 forces the controller to IDLE)
//            warm  - debounced single-cycle "warm" press pulse
//            num   - 4-bit display frame index
//            fail  - game lost
//            done  - egg hatched
//            st_o  - registered copy of st for the display stage
//            heat  - 4-bit current egg temperature
// Modports : master - drives st/warm, observes the outputs
//            slave  - the controller side
// Revision : 1.0 - initial release
// ============================================================================
interface hatch_ctrl_if;
  logic       st;
  logic       warm;
  logic [3:0] num;
  logic       fail;
  logic       done;
  logic       st_o;
  logic [3:0] heat;

  modport master (
    output st,
    output warm,
    input  num,
    input  fail,
    input  done,
    input  st_o,
    input  heat
  );

  modport slave (
    input  st,
    input  warm,
    output num,
    output fail,
    output done,
    output st_o,
    output heat
  );
endinterface
`default_nettype wire

// File: rtl/hatch_ctrl.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module   : hatch_ctrl
// Purpose  : Egg-hatching game controller. Converts warm presses into an egg
//            temperature that decays over time, grows the egg through six
//            stages while the temperature stays in the window, and decides
//            between hatching and failure. Drives the dot-matrix display
//            stage's frame index, fail flag and enable.
// Ports    : clk  - 1 kHz system clock
//            rst  - asynchronous, active-low reset
//            bus  - hatch_ctrl_if.slave (st, warm in; num, fail, done,
//                   st_o, heat out). Every output is a flop.
// Revision : 1.0 - initial release
// ============================================================================
module hatch_ctrl #(
  parameter int HEAT_INIT  = 8,
  parameter int HEAT_LO    = 4,
  parameter int HEAT_HI    = 12,
  parameter int WARM_STEP  = 3,
  parameter int COOL_TICKS = 500,
  parameter int GROW_TICKS = 2000,
  parameter int COLD_MAX   = 3000,
  parameter int ANIM_TICKS = 250
) (
  input  logic        clk,
  input  logic        rst,
  hatch_ctrl_if.slave bus
);

  // Counter widths; a period of 1 still needs a 1-bit counter.
  localparam int c_cool_w = (COOL_TICKS > 1) ? $clog2(COOL_TICKS) : 1;
  localparam int c_grow_w = (GROW_TICKS > 1) ? $clog2(GROW_TICKS) : 1;
  localparam int c_cold_w = (COLD_MAX   > 1) ? $clog2(COLD_MAX)   : 1;
  localparam int c_anim_w = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS) : 1;

  localparam logic [c_cool_w-1:0] c_cool_last = c_cool_w'(COOL_TICKS - 1);
  localparam logic [c_grow_w-1:0] c_grow_last = c_grow_w'(GROW_TICKS - 1);
  localparam logic [c_cold_w-1:0] c_cold_last = c_cold_w'(COLD_MAX - 1);
  localparam logic [c_anim_w-1:0] c_anim_last = c_anim_w'(ANIM_TICKS - 1);

  localparam logic [3:0] c_heat_init = 4'(HEAT_INIT);
  localparam logic [3:0] c_heat_lo   = 4'(HEAT_LO);
  localparam logic [3:0] c_heat_hi   = 4'(HEAT_HI);
  localparam logic [5:0] c_warm_step = 6'(WARM_STEP);
  localparam logic [2:0] c_stage_last = 3'd5;

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_grow  = 3'd1;
  localparam logic [2:0] c_st_hatch = 3'd2;
  localparam logic [2:0] c_st_done  = 3'd3;
  localparam logic [2:0] c_st_fail  = 3'd4;

  // State and datapath registers
  logic [2:0]          r_state;
  logic [3:0]          r_heat;
  logic [2:0]          r_stage;
  logic [c_grow_w-1:0] r_grow_cnt;
  logic [c_cold_w-1:0] r_cold_cnt;
  logic [c_cool_w-1:0] r_cool_cnt;
  logic [c_anim_w-1:0] r_anim_cnt;
  logic                r_phase;
  logic [3:0]          r_num;
  logic                r_fail;
  logic                r_done;
  logic                r_st_o;

  // Next-state values
  logic [2:0]          w_state_nxt;
  logic [3:0]          w_heat_nxt;
  logic [2:0]          w_stage_nxt;
  logic [c_grow_w-1:0] w_grow_nxt;
  logic [c_cold_w-1:0] w_cold_nxt;
  logic [c_cool_w-1:0] w_cool_nxt;
  logic [c_anim_w-1:0] w_anim_nxt;
  logic                w_phase_nxt;
  logic [3:0]          w_num_nxt;
  logic                w_fail_nxt;
  logic                w_done_nxt;

  // Heat arithmetic
  logic                w_cool_tick;
  logic [5:0]          w_heat_add;
  logic [5:0]          w_heat_sub;
  logic [3:0]          w_heat_sat;
  logic                w_over;
  logic                w_cold;

  assign w_over = (r_heat > c_heat_hi);
  assign w_cold = (r_heat < c_heat_lo);

  // Warm and cool apply in the same cycle as a net change; the sum is kept
  // wide so the result can be clamped to 0..15 instead of wrapping.
  always_comb begin
    w_cool_tick = (r_state == c_st_grow) && (r_cool_cnt == c_cool_last);
    w_heat_add  = {2'b00, r_heat} + (bus.warm ? c_warm_step : 6'd0);
    w_heat_sub  = w_heat_add;
    if (w_cool_tick && (w_heat_add != 6'd0)) begin
      w_heat_sub = w_heat_add - 6'd1;
    end
    w_heat_sat = (w_heat_sub > 6'd15) ? 4'hF : w_heat_sub[3:0];
  end

  // Next-state / datapath process
  always_comb begin
    w_state_nxt = r_state;
    w_heat_nxt  = r_heat;
    w_stage_nxt = r_stage;
    w_grow_nxt  = r_grow_cnt;
    w_cold_nxt  = r_cold_cnt;
    w_cool_nxt  = r_cool_cnt;
    w_anim_nxt  = r_anim_cnt;
    w_phase_nxt = r_phase;

    if (!bus.st) begin
      w_state_nxt = c_st_idle;
      w_heat_nxt  = c_heat_init;
      w_stage_nxt = 3'd0;
      w_grow_nxt  = '0;
      w_cold_nxt  = '0;
      w_cool_nxt  = '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          // Clearing here also makes the cool period start on GROW entry.
          w_state_nxt = c_st_grow;
          w_heat_nxt  = c_heat_init;
          w_stage_nxt = 3'd0;
          w_grow_nxt  = '0;
          w_cold_nxt  = '0;
          w_cool_nxt  = '0;
        end
        c_st_grow: begin
          w_cool_nxt = w_cool_tick ? '0 : r_cool_cnt + c_cool_w'(1);
          w_heat_nxt = w_heat_sat;
          // Decisions use the registered heat: overheat > cold > growth.
          if (w_over) begin
            w_state_nxt = c_st_fail;
          end else if (w_cold) begin
            if (r_cold_cnt == c_cold_last) begin
              w_state_nxt = c_st_fail;
            end else begin
              w_cold_nxt = r_cold_cnt + c_cold_w'(1);
            end
          end else begin
            w_cold_nxt = '0;
            if (r_grow_cnt == c_grow_last) begin
              w_grow_nxt = '0;
              if (r_stage == c_stage_last) begin
                w_state_nxt = c_st_hatch;
              end else begin
                w_stage_nxt = r_stage + 3'd1;
              end
            end else begin
              w_grow_nxt = r_grow_cnt + c_grow_w'(1);
            end
          end
        end
        c_st_hatch: begin
          // Two animation frames: phase 0 shows frame 6, phase 1 frame 7.
          if (r_phase && (r_anim_cnt == c_anim_last)) begin
            w_state_nxt = c_st_done;
          end
        end
        c_st_done, c_st_fail: begin
          w_state_nxt = r_state;
        end
        default: begin
          w_state_nxt = c_st_idle;
        end
      endcase
    end

    // Animation timebase restarts on every state change.
    if (w_state_nxt != r_state) begin
      w_anim_nxt  = '0;
      w_phase_nxt = 1'b0;
    end else if (r_anim_cnt == c_anim_last) begin
      w_anim_nxt  = '0;
      w_phase_nxt = ~r_phase;
    end else begin
      w_anim_nxt  = r_anim_cnt + c_anim_w'(1);
    end
  end

  // Output process: decoded from next-state values so the registered
  // outputs change on the same edge as the state.
  always_comb begin
    w_num_nxt  = 4'd0;
    w_fail_nxt = 1'b0;
    w_done_nxt = 1'b0;
    case (w_state_nxt)
      c_st_grow: begin
        w_num_nxt = ((w_heat_nxt < c_heat_lo) && w_phase_nxt) ? 4'd11
                                                              : {1'b0, w_stage_nxt};
      end
      c_st_hatch: begin
        w_num_nxt = w_phase_nxt ? 4'd7 : 4'd6;
      end
      c_st_done: begin
        w_num_nxt  = w_phase_nxt ? 4'd10 : 4'd9;
        w_done_nxt = 1'b1;
      end
      c_st_fail: begin
        w_num_nxt  = 4'd8;
        w_fail_nxt = 1'b1;
      end
      default: begin
        w_num_nxt = 4'd0;
      end
    endcase
  end

  // State register process
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= c_st_idle;
      r_heat     <= c_heat_init;
      r_stage    <= 3'd0;
      r_grow_cnt <= '0;
      r_cold_cnt <= '0;
      r_cool_cnt <= '0;
      r_anim_cnt <= '0;
      r_phase    <= 1'b0;
      r_num      <= 4'd0;
      r_fail     <= 1'b0;
      r_done     <= 1'b0;
      r_st_o     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_heat     <= w_heat_nxt;
      r_stage    <= w_stage_nxt;
      r_grow_cnt <= w_grow_nxt;
      r_cold_cnt <= w_cold_nxt;
      r_cool_cnt <= w_cool_nxt;
      r_anim_cnt <= w_anim_nxt;
      r_phase    <= w_phase_nxt;
      r_num      <= w_num_nxt;
      r_fail     <= w_fail_nxt;
      r_done     <= w_done_nxt;
      r_st_o     <= bus.st;
    end
  end

  assign bus.num  = r_num;
  assign bus.fail = r_fail;
  assign bus.done = r_done;
  assign bus.st_o = r_st_o;
  assign bus.heat = r_heat;

endmodule
`default_nettype wire
